// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types for the I2C target register bank: the protocol state
// enumeration and the two bus-level constants that give meaning to the
// R/W bit and the acknowledge bit.
// No ports; imported by i2c_target_regs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package i2c_pkg;

   // Protocol position of the target within a bus transaction
   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_PTR,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } i2c_tgt_state_e;

   // Value of the R/W bit that requests a read
   localparam logic I2C_READ = 1'b1;

   // Level of SDA that acknowledges a byte
   localparam logic I2C_ACK  = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings the asynchronous SCL/SDA bus lines into the system_clock domain
// and derives the events the protocol engine works from.
// Ports:
//   system_clock  in   sole clock
//   reset_n       in   asynchronous active-low reset
//   scl_i, sda_i  in   raw bus lines (idle high)
//   scl_rise      out  one-cycle pulse on a synchronized SCL 0->1
//   scl_fall      out  one-cycle pulse on a synchronized SCL 1->0
//   start_det     out  SDA fell while SCL was steadily high
//   stop_det      out  SDA rose while SCL was steadily high
//   sda_s         out  synchronized SDA level
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_bus_sync (
   input  logic system_clock,
   input  logic reset_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [1:0] r_sclSync;
   logic [1:0] r_sdaSync;
   logic       r_sclPrev;
   logic       r_sdaPrev;
   logic       w_sclS;
   logic       w_sdaS;

   // Two-flop synchronizers plus one history flop per line. Everything
   // resets to 1 so an idle bus coming out of reset produces no edges.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sclSync <= 2'b11;
         r_sdaSync <= 2'b11;
         r_sclPrev <= 1'b1;
         r_sdaPrev <= 1'b1;
      end else begin
         r_sclSync <= {r_sclSync[0], scl_i};
         r_sdaSync <= {r_sdaSync[0], sda_i};
         r_sclPrev <= r_sclSync[1];
         r_sdaPrev <= r_sdaSync[1];
      end
   end

   assign w_sclS = r_sclSync[1];
   assign w_sdaS = r_sdaSync[1];

   // START/STOP require SCL high on both sides of the SDA change, so an
   // SDA transition can never be confused with a data bit.
   assign scl_rise  =  w_sclS & ~r_sclPrev;
   assign scl_fall  = ~w_sclS &  r_sclPrev;
   assign start_det =  w_sclS &  r_sclPrev &  r_sdaPrev & ~w_sdaS;
   assign stop_det  =  w_sclS &  r_sclPrev & ~r_sdaPrev &  w_sdaS;
   assign sda_s     =  w_sdaS;

endmodule

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
// I2C target with a small byte-wide register bank and an auto-incrementing
// pointer. The first byte of a write sets the pointer, later bytes are
// stored and announced on wr_valid; reads stream the bank from the pointer.
// Ports:
//   system_clock  in   sole clock
//   reset_n       in   asynchronous active-low reset
//   scl_i, sda_i  in   observed bus lines
//   sda_oe        out  1 pulls SDA low (never drives high)
//   busy          out  addressed by the bus master
//   wr_valid      out  one-cycle strobe per stored byte
//   wr_addr       out  bank index of that byte
//   wr_data       out  the stored byte
//   loc_addr      in   local read index
//   loc_rdata     out  bank contents at loc_addr (combinational)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter  logic [6:0] TARGET_ADDR = 7'h50,
   parameter  int         NUM_REGS    = 16,
   localparam int         PTR_W       = $clog2(NUM_REGS)
) (
   input  logic             system_clock,
   input  logic             reset_n,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   output logic             busy,
   output logic             wr_valid,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   input  logic [PTR_W-1:0] loc_addr,
   output logic [7:0]       loc_rdata
);

   i2c_tgt_state_e   r_state;
   i2c_tgt_state_e   w_stateNext;
   logic [3:0]       r_bitCnt;
   logic [3:0]       w_bitCntNext;
   logic [3:0]       w_bitCntInc;
   logic [7:0]       r_shift;
   logic [7:0]       w_shiftNext;
   logic             r_sdaOe;
   logic             w_sdaOeNext;
   logic             r_busy;
   logic             w_busyNext;
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptrNext;
   logic [PTR_W-1:0] w_ptrInc;
   logic             w_wrEn;
   logic [7:0]       w_byte;
   logic             w_lastBit;
   logic [7:0]       r_regs [NUM_REGS];
   logic             r_wrValid;
   logic [PTR_W-1:0] r_wrAddr;
   logic [7:0]       r_wrData;

   logic w_sclRise;
   logic w_sclFall;
   logic w_startDet;
   logic w_stopDet;
   logic w_sdaS;

   i2c_bus_sync u_sync (
      .system_clock (system_clock),
      .reset_n      (reset_n),
      .scl_i        (scl_i),
      .sda_i        (sda_i),
      .scl_rise     (w_sclRise),
      .scl_fall     (w_sclFall),
      .start_det    (w_startDet),
      .stop_det     (w_stopDet),
      .sda_s        (w_sdaS)
   );

   // The byte as it will look once the bit on SDA right now is shifted in;
   // only meaningful on the scl_rise that completes a byte.
   assign w_byte      = {r_shift[6:0], w_sdaS};
   assign w_lastBit   = (r_bitCnt == 4'd7);
   assign w_bitCntInc = r_bitCnt + 4'd1;
   assign w_ptrInc    = r_ptr + 1'b1;

   // Protocol state register together with the datapath it steers.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_bitCnt <= 4'd0;
         r_shift  <= 8'h00;
         r_sdaOe  <= 1'b0;
         r_busy   <= 1'b0;
         r_ptr    <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_bitCnt <= w_bitCntNext;
         r_shift  <= w_shiftNext;
         r_sdaOe  <= w_sdaOeNext;
         r_busy   <= w_busyNext;
         r_ptr    <= w_ptrNext;
      end
   end

   // Next-state logic. STOP and START override whatever the current state
   // is doing. SDA is only ever changed on scl_fall, so the line is stable
   // for the whole SCL high phase. ADDR_ACK and WR_ACK span two SCL falls:
   // the first asserts the ACK, the second releases it and moves on, and
   // r_sdaOe itself tells the two apart. In RD_DATA the bit counter counts
   // SCL rises: 0 means the first bit has not been put on the bus yet, 8
   // means the byte is finished and SDA is handed back for the master ACK.
   always_comb begin
      w_stateNext  = r_state;
      w_bitCntNext = r_bitCnt;
      w_shiftNext  = r_shift;
      w_sdaOeNext  = r_sdaOe;
      w_busyNext   = r_busy;
      w_ptrNext    = r_ptr;
      w_wrEn       = 1'b0;

      if (w_stopDet) begin
         w_stateNext  = IDLE;
         w_bitCntNext = 4'd0;
         w_sdaOeNext  = 1'b0;
         w_busyNext   = 1'b0;
      end else if (w_startDet) begin
         w_stateNext  = ADDR;
         w_bitCntNext = 4'd0;
         w_sdaOeNext  = 1'b0;
         w_busyNext   = 1'b0;
      end else begin
         case (r_state)
            ADDR: begin
               if (w_sclRise) begin
                  w_shiftNext  = w_byte;
                  w_bitCntNext = w_bitCntInc;
                  if (w_lastBit) begin
                     w_bitCntNext = 4'd0;
                     w_stateNext  = (w_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
                  end
               end
            end

            ADDR_ACK: begin
               if (w_sclFall) begin
                  if (!r_sdaOe) begin
                     w_sdaOeNext = 1'b1;
                     w_busyNext  = 1'b1;
                  end else if (r_shift[0] == I2C_READ) begin
                     w_stateNext  = RD_DATA;
                     w_bitCntNext = 4'd0;
                     w_shiftNext  = r_regs[r_ptr];
                     w_sdaOeNext  = ~r_regs[r_ptr][7];
                  end else begin
                     w_stateNext  = WR_PTR;
                     w_bitCntNext = 4'd0;
                     w_sdaOeNext  = 1'b0;
                  end
               end
            end

            WR_PTR, WR_DATA: begin
               if (w_sclRise) begin
                  w_shiftNext  = w_byte;
                  w_bitCntNext = w_bitCntInc;
                  if (w_lastBit) begin
                     w_bitCntNext = 4'd0;
                     w_stateNext  = WR_ACK;
                     if (r_state == WR_PTR) begin
                        w_ptrNext = w_byte[PTR_W-1:0];
                     end else begin
                        w_wrEn    = 1'b1;
                        w_ptrNext = w_ptrInc;
                     end
                  end
               end
            end

            WR_ACK: begin
               if (w_sclFall) begin
                  if (!r_sdaOe) begin
                     w_sdaOeNext = 1'b1;
                  end else begin
                     w_sdaOeNext  = 1'b0;
                     w_stateNext  = WR_DATA;
                     w_bitCntNext = 4'd0;
                  end
               end
            end

            RD_DATA: begin
               if (w_sclRise) begin
                  w_bitCntNext = w_bitCntInc;
               end else if (w_sclFall) begin
                  if (r_bitCnt == 4'd0) begin
                     w_sdaOeNext = ~r_shift[7];
                  end else if (r_bitCnt == 4'd8) begin
                     w_sdaOeNext  = 1'b0;
                     w_stateNext  = RD_ACK;
                     w_bitCntNext = 4'd0;
                  end else begin
                     w_shiftNext = {r_shift[6:0], 1'b0};
                     w_sdaOeNext = ~r_shift[6];
                  end
               end
            end

            RD_ACK: begin
               if (w_sclRise) begin
                  w_ptrNext = w_ptrInc;
                  if (w_sdaS == I2C_ACK) begin
                     w_stateNext  = RD_DATA;
                     w_bitCntNext = 4'd0;
                     w_shiftNext  = r_regs[w_ptrInc];
                  end else begin
                     w_stateNext = IGNORE;
                  end
               end
            end

            default: begin
            end
         endcase
      end
   end

   // Register bank and the write report. The bank is written on the same
   // edge that raises wr_valid, so a local read of that index shows the
   // new value from the following cycle.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= 8'h00;
         end
         r_wrValid <= 1'b0;
         r_wrAddr  <= '0;
         r_wrData  <= 8'h00;
      end else begin
         r_wrValid <= w_wrEn;
         if (w_wrEn) begin
            r_regs[r_ptr] <= w_byte;
            r_wrAddr      <= r_ptr;
            r_wrData      <= w_byte;
         end
      end
   end

   assign sda_oe    = r_sdaOe;
   assign busy      = r_busy;
   assign wr_valid  = r_wrValid;
   assign wr_addr   = r_wrAddr;
   assign wr_data   = r_wrData;
   assign loc_rdata = r_regs[loc_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
// Bus-master bench for i2c_target_regs. The bench plays the I2C initiator
// on a wired-AND SDA line and keeps its own picture of the register bank
// and pointer to predict every ACK, read byte and write report.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_target_regs;
   import i2c_pkg::*;

   localparam int         NUM_REGS    = 16;
   localparam int         PTR_W       = 4;
   localparam logic [6:0] TARGET_ADDR = 7'h50;

   logic             system_clock = 1'b0;
   logic             reset_n;
   logic             sclLine;
   logic             tbSdaLow;
   logic             sda_oe;
   logic             busy;
   logic             wr_valid;
   logic [PTR_W-1:0] wr_addr;
   logic [7:0]       wr_data;
   logic [PTR_W-1:0] loc_addr;
   logic [7:0]       loc_rdata;

   // Open-drain bus: anybody pulling low wins, otherwise the pull-up
   wire sdaBus = (tbSdaLow || sda_oe) ? 1'b0 : 1'b1;

   int assertCount;
   int failCount;
   int oeViol;
   int xCount;
   logic inCond;
   logic sclPrev;
   logic oePrev;

   logic [7:0]       modelRegs [NUM_REGS];
   int               modelPtr;
   logic [7:0]       txData [$];
   logic [PTR_W+7:0] expWrites [$];
   logic [PTR_W+7:0] gotWrites [$];

   i2c_target_regs #(
      .TARGET_ADDR (TARGET_ADDR),
      .NUM_REGS    (NUM_REGS)
   ) dut (
      .system_clock (system_clock),
      .reset_n      (reset_n),
      .scl_i        (sclLine),
      .sda_i        (sdaBus),
      .sda_oe       (sda_oe),
      .busy         (busy),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .loc_addr     (loc_addr),
      .loc_rdata    (loc_rdata)
   );

   always #5 system_clock = ~system_clock;

   // Bus watcher: logs write strobes, flags X on the bus and any change
   // of sda_oe while SCL sits high outside START/STOP or reset.
   always @(negedge system_clock) begin
      if (wr_valid === 1'b1) gotWrites.push_back({wr_addr, wr_data});
      if (reset_n === 1'b1 && ($isunknown(sda_oe) || $isunknown(sdaBus) || $isunknown(sclLine)))
         xCount <= xCount + 1;
      if (sclLine && sclPrev && !inCond && (sda_oe !== oePrev))
         oeViol <= oeViol + 1;
      sclPrev <= sclLine;
      oePrev  <= sda_oe;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge system_clock);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Each bit: SCL low, settle SDA mid-low, SCL high for 8 cycles
   task automatic bitOut(input logic b);
      sclLine = 1'b0;
      tick(4);
      tbSdaLow = ~b;
      tick(4);
      sclLine = 1'b1;
      tick(8);
   endtask

   task automatic bitIn(output logic b);
      sclLine = 1'b0;
      tick(4);
      tbSdaLow = 1'b0;
      tick(4);
      sclLine = 1'b1;
      tick(4);
      b = sdaBus;
      tick(4);
   endtask

   task automatic i2cStart();
      inCond = 1'b1;
      sclLine = 1'b0;
      tick(4);
      tbSdaLow = 1'b0;
      tick(4);
      sclLine = 1'b1;
      tick(8);
      tbSdaLow = 1'b1;
      tick(8);
      inCond = 1'b0;
   endtask

   task automatic i2cStop();
      inCond = 1'b1;
      sclLine = 1'b0;
      tick(4);
      tbSdaLow = 1'b1;
      tick(4);
      sclLine = 1'b1;
      tick(8);
      tbSdaLow = 1'b0;
      tick(8);
      inCond = 1'b0;
   endtask

   task automatic writeByte(input logic [7:0] data, output logic ackBit);
      for (int i = 7; i >= 0; i--) bitOut(data[i]);
      bitIn(ackBit);
   endtask

   task automatic readByte(input logic ackIt, output logic [7:0] data);
      logic b;
      data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bitIn(b);
         data = {data[6:0], b};
      end
      bitOut(ackIt ? I2C_ACK : ~I2C_ACK);
   endtask

   task automatic compareWrites(input string tag);
      checkOutput($sformatf("%s wrCount", tag), 32'(gotWrites.size()), 32'(expWrites.size()));
      for (int i = 0; i < expWrites.size() && i < gotWrites.size(); i++)
         checkOutput($sformatf("%s wr%0d", tag, i), 32'(gotWrites[i]), 32'(expWrites[i]));
      gotWrites.delete();
      expWrites.delete();
   endtask

   // Write transaction: pointer byte, then every byte queued in txData
   task automatic doWrite(input logic [7:0] ptrByte, input string tag);
      logic ackBit;
      i2cStart();
      writeByte({TARGET_ADDR, 1'b0}, ackBit);
      checkOutput($sformatf("%s addrAck", tag), 32'(ackBit), 32'(I2C_ACK));
      checkOutput($sformatf("%s busy", tag), 32'(busy), 32'(1'b1));
      writeByte(ptrByte, ackBit);
      checkOutput($sformatf("%s ptrAck", tag), 32'(ackBit), 32'(I2C_ACK));
      modelPtr = int'(ptrByte) % NUM_REGS;
      foreach (txData[i]) begin
         writeByte(txData[i], ackBit);
         checkOutput($sformatf("%s dataAck%0d", tag, i), 32'(ackBit), 32'(I2C_ACK));
         expWrites.push_back({PTR_W'(modelPtr), txData[i]});
         modelRegs[modelPtr] = txData[i];
         modelPtr = (modelPtr + 1) % NUM_REGS;
      end
      i2cStop();
      checkOutput($sformatf("%s busyAfterStop", tag), 32'(busy), 32'(1'b0));
      compareWrites(tag);
   endtask

   // Read transaction, optionally preceded by a pointer write and a
   // repeated START; the last byte is NACKed.
   task automatic doRead(input logic setPtr, input logic [7:0] ptrByte, input int nBytes, input string tag);
      logic       ackBit;
      logic [7:0] got;
      i2cStart();
      if (setPtr) begin
         writeByte({TARGET_ADDR, 1'b0}, ackBit);
         checkOutput($sformatf("%s wAddrAck", tag), 32'(ackBit), 32'(I2C_ACK));
         writeByte(ptrByte, ackBit);
         checkOutput($sformatf("%s ptrAck", tag), 32'(ackBit), 32'(I2C_ACK));
         modelPtr = int'(ptrByte) % NUM_REGS;
         i2cStart();
      end
      writeByte({TARGET_ADDR, I2C_READ}, ackBit);
      checkOutput($sformatf("%s rAddrAck", tag), 32'(ackBit), 32'(I2C_ACK));
      for (int i = 0; i < nBytes; i++) begin
         readByte(i != nBytes - 1, got);
         checkOutput($sformatf("%s byte%0d", tag, i), 32'(got), 32'(modelRegs[modelPtr]));
         modelPtr = (modelPtr + 1) % NUM_REGS;
      end
      checkOutput($sformatf("%s oeAfterNack", tag), 32'(sda_oe), 32'(1'b0));
      i2cStop();
   endtask

   // One random round: random pointer and data written, then a random
   // window of the bank read back
   task automatic applyStimulus(input int round);
      int n;
      n = int'($urandom_range(1, 4));
      txData.delete();
      for (int i = 0; i < n; i++) txData.push_back(8'($urandom));
      doWrite(8'($urandom_range(0, 255)), $sformatf("rndWr%0d", round));
      doRead(1'b1, 8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), $sformatf("rndRd%0d", round));
   endtask

   task automatic sweepBank(input string tag);
      for (int i = 0; i < NUM_REGS; i++) begin
         loc_addr = PTR_W'(i);
         tick(1);
         checkOutput($sformatf("%s reg%0d", tag, i), 32'(loc_rdata), 32'(modelRegs[i]));
      end
   endtask

   initial begin
      logic ackBit;
      logic b;
      assertCount = 0;
      failCount   = 0;
      oeViol      = 0;
      xCount      = 0;
      inCond      = 1'b1;
      sclPrev     = 1'b1;
      oePrev      = 1'b0;
      modelPtr    = 0;
      foreach (modelRegs[i]) modelRegs[i] = 8'h00;
      reset_n  = 1'b0;
      sclLine  = 1'b1;
      tbSdaLow = 1'b0;
      loc_addr = '0;
      tick(3);

      $display("[TB] reset values");
      checkOutput("rst sda_oe", 32'(sda_oe), 32'(1'b0));
      checkOutput("rst busy", 32'(busy), 32'(1'b0));
      checkOutput("rst wr_valid", 32'(wr_valid), 32'(1'b0));
      checkOutput("rst wr_addr", 32'(wr_addr), 32'(0));
      checkOutput("rst wr_data", 32'(wr_data), 32'(0));
      checkOutput("rst loc_rdata", 32'(loc_rdata), 32'(0));
      reset_n = 1'b1;
      tick(5);
      inCond = 1'b0;

      $display("[TB] write ptr 3, A5 5A");
      txData.delete();
      txData.push_back(8'hA5);
      txData.push_back(8'h5A);
      doWrite(8'h03, "wr1");
      loc_addr = 4'd3;
      tick(1);
      checkOutput("wr1 loc3", 32'(loc_rdata), 32'(8'hA5));
      loc_addr = 4'd4;
      tick(1);
      checkOutput("wr1 loc4", 32'(loc_rdata), 32'(8'h5A));

      $display("[TB] read back from 3 with repeated START");
      doRead(1'b1, 8'h03, 2, "rd1");

      $display("[TB] address mismatch");
      i2cStart();
      writeByte({7'h51, 1'b0}, ackBit);
      checkOutput("miss noAck", 32'(ackBit), 32'(1'b1));
      checkOutput("miss busy", 32'(busy), 32'(1'b0));
      i2cStop();
      txData.delete();
      txData.push_back(8'h3C);
      doWrite(8'h07, "wrAfterMiss");

      $display("[TB] pointer wrap");
      txData.delete();
      txData.push_back(8'h11);
      txData.push_back(8'h22);
      doWrite(8'h0F, "wrap");
      loc_addr = 4'd15;
      tick(1);
      checkOutput("wrap loc15", 32'(loc_rdata), 32'(8'h11));
      loc_addr = 4'd0;
      tick(1);
      checkOutput("wrap loc0", 32'(loc_rdata), 32'(8'h22));

      $display("[TB] read continuing from kept pointer");
      doRead(1'b0, 8'h00, 2, "rdKeep");

      $display("[TB] random rounds");
      for (int r = 0; r < 6; r++) applyStimulus(r);
      sweepBank("bank");

      $display("[TB] STOP after 4 address bits");
      i2cStart();
      bitOut(1'b1);
      bitOut(1'b0);
      bitOut(1'b1);
      bitOut(1'b0);
      i2cStop();
      for (int i = 0; i < 4; i++) bitOut(1'b0);
      bitIn(b);
      checkOutput("midStop noAck", 32'(b), 32'(1'b1));
      checkOutput("midStop busy", 32'(busy), 32'(1'b0));
      i2cStop();

      $display("[TB] reset during read data");
      txData.delete();
      txData.push_back(8'hA5);
      doWrite(8'h03, "preRst");
      i2cStart();
      writeByte({TARGET_ADDR, 1'b0}, ackBit);
      writeByte(8'h03, ackBit);
      i2cStart();
      writeByte({TARGET_ADDR, I2C_READ}, ackBit);
      checkOutput("rst rAddrAck", 32'(ackBit), 32'(I2C_ACK));
      bitIn(b);
      checkOutput("rst bit7", 32'(b), 32'(1'b1));
      sclLine = 1'b0;
      tick(6);
      checkOutput("rst bit6 driven", 32'(sda_oe), 32'(1'b1));
      inCond = 1'b1;
      reset_n = 1'b0;
      #1;
      checkOutput("rst async release", 32'(sda_oe), 32'(1'b0));
      checkOutput("rst busy clear", 32'(busy), 32'(1'b0));
      tick(2);
      sclLine  = 1'b1;
      tbSdaLow = 1'b0;
      reset_n  = 1'b1;
      tick(10);
      inCond = 1'b0;
      foreach (modelRegs[i]) modelRegs[i] = 8'h00;
      modelPtr = 0;
      sweepBank("afterRst");
      checkOutput("afterRst noWrites", 32'(gotWrites.size()), 32'(0));

      checkOutput("sda_oe stable while SCL high", 32'(oeViol), 32'(0));
      checkOutput("no X on bus", 32'(xCount), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
